logic_gate_unit: RTL and testbench



---
 rtl/logic_gate_pkg.sv | 17 +
 rtl/logic_gate_core.sv | 28 ++
 rtl/logic_gate_unit.sv | 111 +++++++++++
 tb/tb_logic_gate_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// rtl/logic_gate_pkg.sv - op encoding shared by the logic gate unit and its core
package logic_gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NAND = 3'd0,
        OP_NOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

endpackage

// File: rtl/logic_gate_core.sv
// rtl/logic_gate_core.sv - combinational bitwise gate selected by op
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] eb,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op_e'(op))
            OP_NAND: result = ~(a & eb);
            OP_NOR:  result = ~(a | eb);
            OP_AND:  result = a & eb;
            OP_OR:   result = a | eb;
            OP_XOR:  result = a ^ eb;
            OP_XNOR: result = ~(a ^ eb);
            OP_NOTA: result = ~a;
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered valid/ready gate unit with accumulator; LOGIC_GATE_UNIT_FLAGS_EN adds result flags
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_mode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    ,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_parity
`endif
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] eb;
    logic [WIDTH-1:0] result;
    logic             accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // A clear coinciding with an accumulate beat makes that beat see zero.
    assign eb       = acc_mode ? (acc_clr ? '0 : acc_q) : b;

    logic_gate_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (a),
        .eb     (eb),
        .result (result)
    );

    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        acc_d   = acc_q;
        if (accept) begin
            valid_d = 1'b1;
            y_d     = result;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
        if (accept && acc_mode) begin
            acc_d = result;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            acc_q   <= '0;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
        end
    end

    assign out_valid = valid_q;
    assign y         = y_q;

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic flag_zero_q, flag_zero_d;
    logic flag_ones_q, flag_ones_d;
    logic flag_parity_q, flag_parity_d;

    always_comb begin
        flag_zero_d   = flag_zero_q;
        flag_ones_d   = flag_ones_q;
        flag_parity_d = flag_parity_q;
        if (accept) begin
            flag_zero_d   = (result == '0);
            flag_ones_d   = (result == '1);
            flag_parity_d = ^result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero_q   <= 1'b0;
            flag_ones_q   <= 1'b0;
            flag_parity_q <= 1'b0;
        end else begin
            flag_zero_q   <= flag_zero_d;
            flag_ones_q   <= flag_ones_d;
            flag_parity_q <= flag_parity_d;
        end
    end

    assign flag_zero   = flag_zero_q;
    assign flag_ones   = flag_ones_q;
    assign flag_parity = flag_parity_q;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// tb/tb_logic_gate_unit.sv - directed bench for logic_gate_unit (WIDTH=8)
module tb_logic_gate_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc_mode;
    logic       acc_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
    logic       flag_zero;
    logic       flag_ones;
    logic       flag_parity;
`endif

    int passed;
    int total;

    logic_gate_unit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_mode  (acc_mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        ,
        .flag_zero   (flag_zero),
        .flag_ones   (flag_ones),
        .flag_parity (flag_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        op        = 3'd0;
        acc_mode  = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;

        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y",         32'(y),         32'h00);
        check("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        check("rst_flags", {29'd0, flag_zero, flag_ones, flag_parity}, 32'd0);
`endif
        rst_n = 1'b1;
        step();

        // basic ops
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = 8'hF0; b = 8'hCC; op = 3'd0;
        step();
        check("nand_y",     32'(y),         32'h3F);
        check("nand_valid", 32'(out_valid), 32'd1);
        op = 3'd1; step(); check("nor_y",  32'(y), 32'h03);
        op = 3'd4; step(); check("xor_y",  32'(y), 32'h3C);
        op = 3'd6; step(); check("nota_y", 32'(y), 32'h0F);

        // back-pressure
        a = 8'hAA; b = 8'h0F; op = 3'd2;
        step();
        check("bp_and_y", 32'(y), 32'h0A);
        out_ready = 1'b0;
        a = 8'h55; op = 3'd7;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_y",     32'(y),         32'h0A);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        step();
        check("bp_release_y", 32'(y), 32'h55);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // accumulate
        acc_clr = 1'b1;
        step();
        acc_clr  = 1'b0;
        acc_mode = 1'b1;
        in_valid = 1'b1;
        op = 3'd3;
        a = 8'h01; b = 8'hFF; step(); check("acc_y1", 32'(y), 32'h01);
        a = 8'h02; step(); check("acc_y2", 32'(y), 32'h03);
        a = 8'h04; step(); check("acc_y3", 32'(y), 32'h07);
        op = 3'd4; a = 8'h07; step(); check("acc_xor", 32'(y), 32'h00);

        // clear coincident with accumulate accept
        op = 3'd3; a = 8'h7F; step(); check("acc_7f", 32'(y), 32'h7F);
        a = 8'h80; acc_clr = 1'b1; step(); check("clr_coinc_y", 32'(y), 32'h80);
        acc_clr = 1'b0;
        a = 8'h00; step(); check("clr_coinc_acc", 32'(y), 32'h80);

        // non-accumulate beat leaves acc alone
        acc_mode = 1'b0; op = 3'd2; a = 8'hFF; b = 8'h11;
        step(); check("plain_and_y", 32'(y), 32'h11);
        acc_mode = 1'b1; op = 3'd3; a = 8'h00;
        step(); check("acc_kept", 32'(y), 32'h80);

        // clear without a beat
        in_valid = 1'b0; acc_clr = 1'b1;
        step(); check("idle_clr_valid", 32'(out_valid), 32'd0);
        acc_clr = 1'b0; in_valid = 1'b1; a = 8'h00;
        step(); check("idle_clr_acc", 32'(y), 32'h00);

        // asynchronous reset with a held result
        a = 8'h3C; step(); check("pre_rst_y", 32'(y), 32'h3C);
        in_valid = 1'b0; out_ready = 1'b0;
        step(); check("pre_rst_hold", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_y",     32'(y),         32'h00);
        in_valid = 1'b1; out_ready = 1'b1; a = 8'h01;
        step(); check("in_rst_no_accept", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step(); check("post_rst_acc", 32'(y), 32'h01);

`ifdef LOGIC_GATE_UNIT_FLAGS_EN
        acc_mode = 1'b0;
        op = 3'd2; a = 8'hFF; b = 8'h00; step();
        check("flg_and_zero",   32'(flag_zero),   32'd1);
        check("flg_and_parity", 32'(flag_parity), 32'd0);
        op = 3'd5; a = 8'h12; b = 8'h12; step();
        check("flg_xnor_y",      32'(y),           32'hFF);
        check("flg_xnor_ones",   32'(flag_ones),   32'd1);
        check("flg_xnor_parity", 32'(flag_parity), 32'd0);
        op = 3'd7; a = 8'h07; step();
        check("flg_pass_parity", 32'(flag_parity), 32'd1);
        check("flg_pass_zero",   32'(flag_zero),   32'd0);
`endif

        in_valid = 1'b0;
        step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
